sopc_gpio_irq_pio: RTL and testbench

Parametrised successor to the team's Avalon-MM bidirectional PIO. It keeps per-bit direction and data registers and atomic set/clear writes. It adds a WIDTH generalisation, input synchronisers, per-bit edge capture with selectable edge type, an interrupt mask and a level interrupt output. It sits on the SOPC system bus as an e_avalon_slave with zero wait states, and its irq output connects to the CPU interrupt controller.

---
 rtl/sopc_gpio_irq_pio_if.sv | 25 ++
 rtl/sopc_gpio_irq_pio.sv | 94 +++++++++
 tb/tb_sopc_gpio_irq_pio.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sopc_gpio_irq_pio_if.sv
// Avalon-MM slave bus bundle for the GPIO PIO: word address, select, write strobe and data.
// readdata is registered inside the slave and valid one clock after the address is presented.
interface sopc_gpio_irq_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/sopc_gpio_irq_pio.sv
// Bidirectional GPIO with per-bit direction, set/clear writes, synchronised inputs,
// sticky edge capture (W1C) and a masked level interrupt.
module sopc_gpio_irq_pio #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic                clk,
    input  logic                reset,
    sopc_gpio_irq_pio_if.slave  bus,
    output logic                irq,
    inout  wire  [WIDTH-1:0]    bidir_port
);

    logic [WIDTH-1:0]             r_data_dir;
    logic [WIDTH-1:0]             r_data_out;
    logic [WIDTH-1:0]             r_irq_mask;
    logic [WIDTH-1:0]             r_edge_cap;
    logic [WIDTH-1:0]             r_prev;
    logic [SYNC_STAGES*WIDTH-1:0] r_sync;
    logic [31:0]                  r_readdata;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_sync_in;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rd_mux;
    logic [31:0]      w_rd_word;

    assign w_wr      = bus.chipselect & ~bus.write_n;
    assign w_wd      = bus.writedata[WIDTH-1:0];
    assign w_sync_in = r_sync[SYNC_STAGES*WIDTH-1 -: WIDTH];
    assign w_clr     = (w_wr && bus.address == 3'd3) ? w_wd : '0;

    always_comb begin
        case (EDGE_TYPE)
            0:       w_edge = w_sync_in & ~r_prev;
            1:       w_edge = ~w_sync_in & r_prev;
            default: w_edge = w_sync_in ^ r_prev;
        endcase
    end

    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            3'd0:    w_rd_mux = w_sync_in;
            3'd1:    w_rd_mux = r_data_dir;
            3'd2:    w_rd_mux = r_irq_mask;
            3'd3:    w_rd_mux = r_edge_cap;
            default: w_rd_mux = '0;
        endcase
        w_rd_word = '0;
        w_rd_word[WIDTH-1:0] = w_rd_mux;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_dir <= RESET_DIR;
            r_data_out <= RESET_OUT;
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            r_prev     <= '0;
            r_sync     <= '0;
            r_readdata <= '0;
        end else begin
            r_sync     <= {r_sync[(SYNC_STAGES-1)*WIDTH-1:0], bidir_port};
            r_prev     <= w_sync_in;
            r_readdata <= w_rd_word;
            // A new edge in the same cycle as its W1C keeps the bit set.
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
            if (w_wr) begin
                case (bus.address)
                    3'd0:    r_data_out <= w_wd;
                    3'd1:    r_data_dir <= w_wd;
                    3'd2:    r_irq_mask <= w_wd;
                    3'd4:    r_data_out <= r_data_out | w_wd;
                    3'd5:    r_data_out <= r_data_out & ~w_wd;
                    default: ;
                endcase
            end
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = |(r_edge_cap & r_irq_mask);

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign bidir_port[i] = r_data_dir[i] ? r_data_out[i] : 1'bz;
    end

endmodule

// File: tb/tb_sopc_gpio_irq_pio.sv
// Self-checking bench: a 32-bit rising-edge instance driven from external pins and an
// 8-bit any-edge instance with output-only pins; reads are scoreboarded against a queue.
module tb_sopc_gpio_irq_pio;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        bit          sel;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq_m;
    logic        irq_n;
    logic [31:0] tb_oe;
    logic [31:0] tb_drv;
    wire  [31:0] pins_m;
    wire  [7:0]  pins_n;

    int          n_tests = 0;
    int          n_fail  = 0;
    rd_exp_t     rd_q[$];
    logic        rd_issue = 1'b0;
    logic        rd_pend  = 1'b0;

    sopc_gpio_irq_pio_if bus_m ();
    sopc_gpio_irq_pio_if bus_n ();

    sopc_gpio_irq_pio #(
        .WIDTH       (32),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (0),
        .RESET_DIR   (32'h0),
        .RESET_OUT   (32'h0)
    ) u_dut_m (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_m),
        .irq        (irq_m),
        .bidir_port (pins_m)
    );

    sopc_gpio_irq_pio #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (2),
        .RESET_DIR   (8'hFF),
        .RESET_OUT   (8'hA5)
    ) u_dut_n (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_n),
        .irq        (irq_n),
        .bidir_port (pins_n)
    );

    for (genvar i = 0; i < 32; i++) begin : g_drv
        assign pins_m[i] = tb_oe[i] ? tb_drv[i] : 1'bz;
    end

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus_m.address = 3'd0; bus_m.chipselect = 1'b0; bus_m.write_n = 1'b1;
        bus_m.writedata = '0;
        bus_n.address = 3'd0; bus_n.chipselect = 1'b0; bus_n.write_n = 1'b1;
        bus_n.writedata = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input bit sel, input logic [2:0] a, input logic [31:0] d);
        if (sel) begin
            bus_n.address = a; bus_n.chipselect = 1'b1; bus_n.write_n = 1'b0;
            bus_n.writedata = d;
        end else begin
            bus_m.address = a; bus_m.chipselect = 1'b1; bus_m.write_n = 1'b0;
            bus_m.writedata = d;
        end
        tick(1);
        bus_idle();
    endtask

    task automatic bus_rd(input bit sel, input logic [2:0] a, input logic [31:0] exp,
                          input string tag);
        if (sel) begin
            bus_n.address = a; bus_n.chipselect = 1'b1; bus_n.write_n = 1'b1;
        end else begin
            bus_m.address = a; bus_m.chipselect = 1'b1; bus_m.write_n = 1'b1;
        end
        rd_q.push_back('{tag: tag, exp: exp, sel: sel});
        rd_issue = 1'b1;
        tick(1);
        rd_issue = 1'b0;
        bus_idle();
    endtask

    always @(posedge clk) rd_pend <= rd_issue;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                chk_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk_eq(e.tag, e.sel ? bus_n.readdata : bus_m.readdata, e.exp);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        tb_oe  = '1;
        tb_drv = '0;
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_irq", {31'd0, irq_m}, 32'd0);
        chk_eq("n_rst_pins", {24'd0, pins_n}, 32'hA5);
        reset = 1'b0;

        bus_rd(0, 3'd1, 32'h0, "rst_dir");
        bus_rd(0, 3'd2, 32'h0, "rst_mask");
        bus_rd(0, 3'd3, 32'h0, "rst_cap");
        bus_rd(0, 3'd0, 32'h0, "rst_pins");
        chk_eq("rst_irq_after", {31'd0, irq_m}, 32'd0);

        // Output path and atomic set/clear on the low byte.
        tb_oe = 32'hFFFF_FF00;
        bus_wr(0, 3'd1, 32'h0000_00FF);
        bus_wr(0, 3'd0, 32'h0000_000F);
        chk_eq("out_wr", pins_m, 32'h0000_000F);
        bus_wr(0, 3'd4, 32'h0000_00F0);
        chk_eq("out_set", pins_m, 32'h0000_00FF);
        bus_wr(0, 3'd5, 32'h0000_0081);
        chk_eq("out_clr", pins_m, 32'h0000_007E);
        tick(3);
        bus_rd(0, 3'd0, 32'h0000_007E, "rd_sync");
        bus_rd(0, 3'd1, 32'h0000_00FF, "rd_dir");
        bus_rd(0, 3'd3, 32'h0000_00FF, "cap_outdir");
        chk_eq("irq_unmasked_off", {31'd0, irq_m}, 32'd0);

        // Back to inputs, clear stray captures.
        bus_wr(0, 3'd1, 32'h0);
        tb_oe = '1;
        tick(4);
        bus_wr(0, 3'd3, 32'hFFFF_FFFF);
        bus_rd(0, 3'd3, 32'h0, "cap_clr_all");

        // Rising edge on pin 2: irq exactly SYNC_STAGES+1 edges after the pin change.
        bus_wr(0, 3'd2, 32'h4);
        tb_drv[2] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("irq_early", {31'd0, irq_m}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk_eq("irq_rise", {31'd0, irq_m}, 32'd1);
        tick(1);
        bus_rd(0, 3'd3, 32'h4, "cap_rise");

        tb_drv[2] = 1'b0;
        tick(4);
        bus_rd(0, 3'd3, 32'h4, "cap_nofall");
        bus_wr(0, 3'd3, 32'h4);
        chk_eq("irq_w1c", {31'd0, irq_m}, 32'd0);
        bus_rd(0, 3'd3, 32'h0, "cap_w1c");

        // Masking: bits 0 and 3 captured, only bit 0 enabled.
        bus_wr(0, 3'd2, 32'h1);
        tb_drv = 32'h9;
        tick(4);
        chk_eq("irq_mask_on", {31'd0, irq_m}, 32'd1);
        bus_rd(0, 3'd3, 32'h9, "cap_two");
        bus_wr(0, 3'd3, 32'h1);
        chk_eq("irq_mask_off", {31'd0, irq_m}, 32'd0);
        bus_rd(0, 3'd3, 32'h8, "cap_keep");
        bus_wr(0, 3'd2, 32'h8);
        chk_eq("irq_remask", {31'd0, irq_m}, 32'd1);

        // Narrow instance: outputs from reset, power-up edges seen by the any-edge detector.
        bus_rd(1, 3'd0, 32'hA5, "n_sync");
        bus_rd(1, 3'd1, 32'hFF, "n_dir");
        bus_rd(1, 3'd3, 32'hA5, "n_pwrcap");
        bus_wr(1, 3'd3, 32'hFFFF_FFFF);
        bus_rd(1, 3'd3, 32'h0, "n_cap_clr");
        bus_wr(1, 3'd0, 32'hFFFF_FF00);
        chk_eq("n_pins_wr", {24'd0, pins_n}, 32'h0);
        tick(4);
        for (int a = 0; a < 8; a++) begin
            logic [31:0] e;
            e = (a == 1) ? 32'hFF : (a == 3) ? 32'hA5 : 32'h0;
            bus_rd(1, 3'(a), e, $sformatf("n_rd%0d", a));
        end

        // Edge detected in the same cycle as a W1C of that bit: set wins.
        bus_wr(1, 3'd3, 32'hFF);
        bus_wr(1, 3'd2, 32'h1);
        bus_rd(1, 3'd3, 32'h0, "n_pre_coll");
        bus_wr(1, 3'd4, 32'h1);
        tick(2);
        bus_wr(1, 3'd3, 32'h1);
        chk_eq("coll_irq", {31'd0, irq_n}, 32'd1);
        bus_rd(1, 3'd3, 32'h1, "coll_cap");
        bus_wr(1, 3'd3, 32'h1);
        chk_eq("coll_clr", {31'd0, irq_n}, 32'd0);

        // Asynchronous reset in mid-cycle.
        #2;
        reset = 1'b1;
        #1;
        chk_eq("rst_mid_irq", {31'd0, irq_m}, 32'd0);
        chk_eq("rst_mid_rd", bus_m.readdata, 32'h0);
        chk_eq("rst_mid_pins", {24'd0, pins_n}, 32'hA5);
        tick(1);
        reset = 1'b0;
        tick(2);
        chk_eq("sb_drained", rd_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
